// File: rtl/mem_access_unit.sv
// Memory stage: turns execute results into data-bus requests, holds them until the bus answers,
// and emits one registered writeback result per transaction. Optional MEM_MISALIGN_TRAP_EN adds the misalign output.
module mem_access_unit #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [1:0]        in_size,
    input  logic              in_sext,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [XLEN-1:0]   in_alu,
    output logic              dreq_valid,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [1:0]        dreq_size,
    output logic [7:0]        dreq_strobe,
    output logic [XLEN-1:0]   dreq_data,
    input  logic              dresp_data_ok,
    input  logic [XLEN-1:0]   dresp_data,
    output logic              out_valid,
    output logic [XLEN-1:0]   out_data,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic              misalign,
`endif
    output logic              stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT state;
    stateT nextState;

    logic              isMem;
    logic              isStore;
    logic              trapC;
    logic [7:0]        strobeBase;
    logic [XLEN-1:0]   loadShift;
    logic [XLEN-1:0]   loadResult;

    logic              reqSext;
    logic              reqIsStore;

    logic              dreqValidNxt;
    logic [ADDR_W-1:0] dreqAddrNxt;
    logic [1:0]        dreqSizeNxt;
    logic [7:0]        dreqStrobeNxt;
    logic [XLEN-1:0]   dreqDataNxt;
    logic              outValidNxt;
    logic [XLEN-1:0]   outDataNxt;
    logic              reqSextNxt;
    logic              reqIsStoreNxt;

    assign isMem   = (in_op == 2'b01) || (in_op == 2'b10);
    assign isStore = (in_op == 2'b10);

`ifdef MEM_MISALIGN_TRAP_EN
    // Natural alignment check for the incoming access size
    always_comb begin
        trapC = 1'b0;
        unique case (in_size)
            2'b01:   trapC = in_addr[0];
            2'b10:   trapC = |in_addr[1:0];
            2'b11:   trapC = |in_addr[2:0];
            default: trapC = 1'b0;
        endcase
        trapC = trapC & isMem;
    end
`else
    assign trapC = 1'b0;
`endif

    always_comb begin
        strobeBase = 8'h01;
        unique case (in_size)
            2'b00:   strobeBase = 8'h01;
            2'b01:   strobeBase = 8'h03;
            2'b10:   strobeBase = 8'h0F;
            default: strobeBase = 8'hFF;
        endcase
    end

    // Lane-align the returned word, then truncate and extend per the latched size/sext
    always_comb begin
        loadShift  = dresp_data >> {dreq_addr[2:0], 3'b000};
        loadResult = loadShift;
        unique case (dreq_size)
            2'b00:   loadResult = reqSext ? {{(XLEN-8){loadShift[7]}}, loadShift[7:0]}
                                          : {{(XLEN-8){1'b0}}, loadShift[7:0]};
            2'b01:   loadResult = reqSext ? {{(XLEN-16){loadShift[15]}}, loadShift[15:0]}
                                          : {{(XLEN-16){1'b0}}, loadShift[15:0]};
            2'b10:   loadResult = reqSext ? {{(XLEN-32){loadShift[31]}}, loadShift[31:0]}
                                          : {{(XLEN-32){1'b0}}, loadShift[31:0]};
            default: loadResult = loadShift;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (in_valid) nextState = (isMem && !trapC) ? REQ : DONE;
            REQ:     if (dresp_data_ok) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Handshake outputs plus next values of every registered output
    always_comb begin
        in_ready      = (state == IDLE);
        stall         = (in_valid & (state != IDLE)) | ((state == IDLE) & in_valid & isMem);
        dreqValidNxt  = dreq_valid;
        dreqAddrNxt   = dreq_addr;
        dreqSizeNxt   = dreq_size;
        dreqStrobeNxt = dreq_strobe;
        dreqDataNxt   = dreq_data;
        outValidNxt   = 1'b0;
        outDataNxt    = out_data;
        reqSextNxt    = reqSext;
        reqIsStoreNxt = reqIsStore;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    if (isMem && !trapC) begin
                        dreqValidNxt  = 1'b1;
                        dreqAddrNxt   = in_addr;
                        dreqSizeNxt   = in_size;
                        dreqStrobeNxt = isStore ? (strobeBase << in_addr[2:0]) : 8'h00;
                        dreqDataNxt   = in_wdata << {in_addr[2:0], 3'b000};
                        reqSextNxt    = in_sext;
                        reqIsStoreNxt = isStore;
                    end else begin
                        outValidNxt = 1'b1;
                        outDataNxt  = isMem ? '0 : in_alu;
                    end
                end
            end
            REQ: begin
                if (dresp_data_ok) begin
                    dreqValidNxt = 1'b0;
                    outValidNxt  = 1'b1;
                    outDataNxt   = reqIsStore ? '0 : loadResult;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dreq_valid  <= 1'b0;
            dreq_addr   <= '0;
            dreq_size   <= 2'b00;
            dreq_strobe <= 8'h00;
            dreq_data   <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            reqSext     <= 1'b0;
            reqIsStore  <= 1'b0;
        end else begin
            dreq_valid  <= dreqValidNxt;
            dreq_addr   <= dreqAddrNxt;
            dreq_size   <= dreqSizeNxt;
            dreq_strobe <= dreqStrobeNxt;
            dreq_data   <= dreqDataNxt;
            out_valid   <= outValidNxt;
            out_data    <= outDataNxt;
            reqSext     <= reqSextNxt;
            reqIsStore  <= reqIsStoreNxt;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // Flag rides alongside the single out_valid cycle of a trapped access
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) misalign <= 1'b0;
        else        misalign <= (state == IDLE) && in_valid && trapC;
    end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with an expected-result queue and a small reference model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'b00;
    logic [1:0]  in_size = 2'b00;
    logic        in_sext = 1'b0;
    logic [63:0] in_addr = '0;
    logic [63:0] in_wdata = '0;
    logic [63:0] in_alu = '0;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [1:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_data_ok = 1'b0;
    logic [63:0] dresp_data = '0;
    logic        out_valid;
    logic [63:0] out_data;
    logic        stall;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int passCount = 0;
    int failCount = 0;
    int totalCount = 0;
    logic [63:0] expQ[$];

    mem_access_unit #(.XLEN(64), .ADDR_W(64)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_size(in_size),
        .in_sext(in_sext), .in_addr(in_addr), .in_wdata(in_wdata), .in_alu(in_alu),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .out_valid(out_valid), .out_data(out_data),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign(misalign),
`endif
        .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        totalCount++;
        assert (got === exp) passCount++;
        else begin
            failCount++;
            $error("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] popExp();
        logic [63:0] v;
        v = 64'hDEAD_DEAD_DEAD_DEAD;
        if (expQ.size() != 0) v = expQ.pop_front();
        return v;
    endfunction

    // Byte-wise reference for load extraction and extension
    function automatic logic [63:0] modelLoad(input logic [63:0] rd, input logic [1:0] sz,
                                              input logic sx, input int lane);
        int nb;
        logic [63:0] v;
        nb = 1 << sz;
        v  = '0;
        for (int b = 0; b < nb; b++)
            if (lane + b < 8) v[8*b +: 8] = rd[8*(lane+b) +: 8];
        if (sx && v[8*nb-1])
            for (int b = nb; b < 8; b++) v[8*b +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [7:0] modelStrobe(input logic [1:0] sz, input int lane);
        logic [7:0] s;
        s = '0;
        for (int b = 0; b < (1 << sz); b++)
            if (lane + b < 8) s[lane+b] = 1'b1;
        return s;
    endfunction

    // One full transaction: accept in IDLE, serve the bus after waitCyc cycles, check DONE pulse
    task automatic doOp(input string tag, input logic [1:0] op, input logic [1:0] size,
                        input logic sext, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] alu, input int waitCyc, input logic [63:0] rdata);
        logic isMem;
        logic isStore;
        logic [63:0] expOut;
        logic [63:0] expData;
        logic [7:0] expStrb;
        int lane;
        int cyc;
        isMem   = (op == 2'b01) || (op == 2'b10);
        isStore = (op == 2'b10);
        lane    = int'(addr[2:0]);
        expStrb = isStore ? modelStrobe(size, lane) : 8'h00;
        expData = wdata << (8 * lane);
        expOut  = (op == 2'b01) ? modelLoad(rdata, size, sext, lane) : (isStore ? 64'd0 : alu);

        check({tag, "_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_op = op; in_size = size; in_sext = sext;
        in_addr = addr; in_wdata = wdata; in_alu = alu;
        expQ.push_back(expOut);
        #1;
        check({tag, "_stall_idle"}, 64'(stall), 64'(isMem));
        step();
        in_addr  = {$urandom, $urandom};
        in_wdata = {$urandom, $urandom};
        in_size  = 2'($urandom);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            if (isMem) begin
                check({tag, "_dreq_valid"}, 64'(dreq_valid), 64'd1);
                check({tag, "_dreq_addr"}, dreq_addr, addr);
                check({tag, "_dreq_size"}, 64'(dreq_size), 64'(size));
                check({tag, "_dreq_strobe"}, 64'(dreq_strobe), 64'(expStrb));
                if (isStore) check({tag, "_dreq_data"}, dreq_data, expData);
                check({tag, "_stall_req"}, 64'(stall), 64'd1);
            end
            dresp_data_ok = (cyc == waitCyc);
            dresp_data    = dresp_data_ok ? rdata : {$urandom, $urandom};
            step();
            cyc++;
        end
        dresp_data_ok = 1'b0;
        check({tag, "_no_timeout"}, 64'(cyc < 40), 64'd1);
        check({tag, "_latency"}, 64'(1 + cyc), isMem ? 64'(2 + waitCyc) : 64'd1);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_out_data"}, out_data, popExp());
        check({tag, "_dreq_off"}, 64'(dreq_valid), 64'd0);
        check({tag, "_stall_done"}, 64'(stall), 64'd1);
`ifdef MEM_MISALIGN_TRAP_EN
        check({tag, "_misalign"}, 64'(misalign), 64'd0);
`endif
        in_valid = 1'b0;
        step();
        check({tag, "_pulse_end"}, 64'(out_valid), 64'd0);
        check({tag, "_out_hold"}, out_data, expOut);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        check("rst_dreq_valid", 64'(dreq_valid), 64'd0);
        check("rst_dreq_addr", dreq_addr, 64'd0);
        check("rst_dreq_data", dreq_data, 64'd0);
        check("rst_dreq_strobe", 64'(dreq_strobe), 64'd0);
        check("rst_dreq_size", 64'(dreq_size), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
`ifdef MEM_MISALIGN_TRAP_EN
        check("rst_misalign", 64'(misalign), 64'd0);
`endif
        #3 reset = 1'b1;
        step();

        doOp("nonmem",    2'b00, 2'b00, 1'b0, 64'h0,    64'h0,    64'h1234, 0, 64'h0);
        doOp("reserved",  2'b11, 2'b11, 1'b1, 64'h8,    64'h0,    64'hCAFE_F00D_0000_0001, 0, 64'h0);
        doOp("ldb_sext",  2'b01, 2'b00, 1'b1, 64'h1003, 64'h0,    64'h0, 3, 64'h0000_0000_8000_0000);
        check("ldb_sext_const", out_data, 64'hFFFF_FFFF_FFFF_FF80);
        doOp("sth",       2'b10, 2'b01, 1'b0, 64'h2006, 64'hBEEF, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        check("sth_strobe_const", 64'(dut.dreq_strobe), 64'hC0);
        check("sth_data_const", dut.dreq_data, 64'hBEEF_0000_0000_0000);
        doOp("ldw_zext",  2'b01, 2'b10, 1'b0, 64'h10,   64'h0,    64'h0, 0, 64'h1111_1111_FFFF_FFFF);
        check("ldw_zext_const", out_data, 64'h0000_0000_FFFF_FFFF);
        doOp("ldh_sext",  2'b01, 2'b01, 1'b1, 64'h22,   64'h0,    64'h0, 2, 64'h0000_0000_9ABC_0000);
        doOp("ldh_zext",  2'b01, 2'b01, 1'b0, 64'h22,   64'h0,    64'h0, 0, 64'h0000_0000_9ABC_0000);
        doOp("ldd",       2'b01, 2'b11, 1'b1, 64'h38,   64'h0,    64'h0, 1, 64'h8765_4321_0FED_CBA9);
        doOp("stb_lane7", 2'b10, 2'b00, 1'b0, 64'h7,    64'h5A,   64'h0, 0, 64'h0);
        doOp("std",       2'b10, 2'b11, 1'b0, 64'h40,   64'h0123_4567_89AB_CDEF, 64'h0, 2, 64'h0);
        doOp("stw_lane4", 2'b10, 2'b10, 1'b0, 64'h104,  64'hA5A5_1234, 64'h0, 0, 64'h0);
        doOp("ldb_zext",  2'b01, 2'b00, 1'b0, 64'h5,    64'h0,    64'h0, 4, 64'h00F1_0000_0000_0000);

        // Stray bus completion while idle must not produce a result
        dresp_data_ok = 1'b1;
        dresp_data = 64'h1;
        step();
        dresp_data_ok = 1'b0;
        check("idle_dataok_out_valid", 64'(out_valid), 64'd0);
        check("idle_dataok_dreq", 64'(dreq_valid), 64'd0);

        // Reset asserted while a load is in flight
        in_valid = 1'b1; in_op = 2'b01; in_size = 2'b11; in_sext = 1'b0; in_addr = 64'h300;
        step();
        in_valid = 1'b0;
        check("midreq_dreq_on", 64'(dreq_valid), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("midreq_dreq_off", 64'(dreq_valid), 64'd0);
        check("midreq_out_valid", 64'(out_valid), 64'd0);
        check("midreq_addr_clr", dreq_addr, 64'd0);
        #1 reset = 1'b1;
        dresp_data_ok = 1'b1;
        dresp_data = 64'h55;
        step();
        check("late_ok_out_valid0", 64'(out_valid), 64'd0);
        step();
        dresp_data_ok = 1'b0;
        check("late_ok_out_valid1", 64'(out_valid), 64'd0);
        check("late_ok_dreq", 64'(dreq_valid), 64'd0);
        check("late_ok_ready", 64'(in_ready), 64'd1);

        doOp("post_reset", 2'b00, 2'b00, 1'b0, 64'h0, 64'h0, 64'h7777, 0, 64'h0);

`ifdef MEM_MISALIGN_TRAP_EN
        in_valid = 1'b1; in_op = 2'b01; in_size = 2'b11; in_sext = 1'b0; in_addr = 64'h4;
        expQ.push_back(64'd0);
        #1;
        check("mis_stall", 64'(stall), 64'd1);
        step();
        in_valid = 1'b0;
        check("mis_out_valid", 64'(out_valid), 64'd1);
        check("mis_flag", 64'(misalign), 64'd1);
        check("mis_no_dreq", 64'(dreq_valid), 64'd0);
        check("mis_out_data", out_data, popExp());
        step();
        check("mis_flag_clr", 64'(misalign), 64'd0);
        check("mis_pulse_end", 64'(out_valid), 64'd0);
        check("mis_dreq_still_off", 64'(dreq_valid), 64'd0);
`endif

        check("queue_drained", 64'(expQ.size()), 64'd0);
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
